conv_14_acc_requant: RTL and testbench
======================================

Name: conv_14_acc_requant

Overview:
- Consumer-side counterpart to the conv_14 signed 16x8 multiplier array.
- Accepts a stream of signed 24-bit products, accumulates NUM_TERMS of them per output pixel, then requantizes the sum back to 16-bit activation width.
- Requantization is round-half-up arithmetic right shift followed by saturation.
- Sits between the multiplier outputs and the conv_14 output FIFO; valid/ready handshake on both sides.

Parameters:
- PROD_WIDTH, 24, width of signed incoming product.
- ACC_WIDTH, 32, width of signed accumulator; must be >= PROD_WIDTH + ceil(log2(NUM_TERMS)).
- OUT_WIDTH, 16, width of signed output activation.
- NUM_TERMS, 9, products summed per output (3x3 kernel); legal range 1..256.
- SHIFT, 8, requantization right-shift amount; legal range 0..ACC_WIDTH-1.

Ports:
- ap_clk, in, 1, clock; all state on the rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- prod_din, in, PROD_WIDTH, signed product.
- prod_valid, in, 1, prod_din valid.
- prod_ready, out, 1, block accepts prod_din this cycle.
- dout, out, OUT_WIDTH, signed requantized result.
- dout_valid, out, 1, dout holds a result.
- dout_ready, in, 1, downstream accepts dout.
- sat_flag, out, 1, dout was clipped; qualified by dout_valid.

Behaviour:
- Reset (async assert, sync release): acc=0, term count=0, dout=0, dout_valid=0, sat_flag=0. Any partial sum is discarded.
- Product acceptance: a product is accepted when prod_valid && prod_ready. prod_din is sign-extended to ACC_WIDTH and added to acc. The accumulator wraps in two's complement and never saturates internally.
- Counter: term count increments per accepted product. On reaching NUM_TERMS-1 with an accept, the cycle is "final":
  - final sum = acc + prod_din;
  - acc and count clear to 0;
  - result is registered into dout/sat_flag and dout_valid=1 on the next edge.
- Latency: 1 cycle from final accept to dout_valid.
- Requantization:
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT. Add term is omitted when SHIFT=0; computed at ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - If r > 2^(OUT_WIDTH-1)-1: dout = max positive, sat_flag=1.
  - If r < -2^(OUT_WIDTH-1): dout = min negative, sat_flag=1.
  - Otherwise dout = r, sat_flag=0.
- Output register: single entry. dout_valid clears on dout_valid && dout_ready unless a new final accept occurs in the same cycle. In that case dout_valid stays 1 and dout is replaced (back-to-back, no bubble).
- prod_ready:
  - Combinational: 0 only when the next accept would be final AND dout_valid=1 AND dout_ready=0; else 1.
  - Non-final terms are always accepted, even while the output is stalled.
- Stability: dout and sat_flag are held stable while dout_valid && !dout_ready.
- NUM_TERMS=1: every accept is final. Throughput stays 1 per cycle when dout_ready=1.
- No combinational path from prod_din or prod_valid to any output. The only combinational path to prod_ready is from dout_ready.

Optional Feature:
- Macro: CONV_14_ACC_RELU_EN.
- Defined:
  - Negative r is forced to 0 before saturation, with sat_flag=0.
  - Positive saturation is unchanged.
- Undefined: signed output as specified above. No ReLU logic is present.

Test Plan:
- Nine products of 256, dout_ready=1 -> one cycle after the 9th accept: dout_valid=1, dout=9 ((2304+128)>>8), sat_flag=0.
- Nine products of 1000 -> dout=35. One product of -129 plus eight 0s -> dout=-1. One product of -128 plus eight 0s -> dout=0.
- Saturation:
  - Nine products of 8388607 -> dout=32767, sat_flag=1.
  - Nine products of -8388608 -> dout=-32768, sat_flag=1.
  - With CONV_14_ACC_RELU_EN: the negative case gives dout=0, sat_flag=0.
- Back-pressure:
  - Hold dout_ready=0 after the first result and stream 9 more products with prod_valid=1 -> 8 accepted, prod_ready=0 on the 9th; first dout unchanged.
  - Raise dout_ready -> same cycle prod_ready=1, 9th accepted; next cycle dout = second result, dout_valid stays 1.
- Reset mid-operation: accept 4 products of 1000, pulse ap_rst_n low asynchronously, then 9 products of 256 -> dout=9 (partial sum discarded); all outputs 0 during reset.
- Continuous stream of 90 random products with random dout_ready -> 10 results matching a reference model. No product lost or duplicated, and dout never changes while stalled.

Source files
------------

// File: rtl/conv_14_acc_requant.sv
// Accumulates NUM_TERMS signed products per pixel, then rounds, shifts and saturates the sum to OUT_WIDTH.
// Optional ReLU on the requantized value is enabled by defining CONV_14_ACC_RELU_EN.
module conv_14_acc_requant #(
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_TERMS  = 9,
  parameter int SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  sat_flag
);

  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [ACC_WIDTH:0] RND_ADD =
    (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH:0] MAX_POS =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_NEG =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 sat_q, sat_d;

  logic                        last_term_s, accept_s, final_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s, sum_s;
  logic signed [ACC_WIDTH:0]   sum_ext_s, rnd_s, r_s;
  logic [OUT_WIDTH-1:0]        q_dout_s;
  logic                        q_sat_s;

  // The final term may only be taken when the output slot is free or draining this cycle.
  assign last_term_s = (cnt_q == CNT_LAST);
  assign prod_ready  = !(last_term_s && dout_valid_q && !dout_ready);
  assign accept_s    = prod_valid && prod_ready;
  assign final_s     = accept_s && last_term_s;

  // Requantize the running sum including the product being offered this cycle.
  always_comb begin
    prod_ext_s = ACC_WIDTH'($signed(prod_din));
    sum_s      = acc_q + prod_ext_s;
    sum_ext_s  = {sum_s[ACC_WIDTH-1], sum_s};
    rnd_s      = sum_ext_s + RND_ADD;
    r_s        = rnd_s >>> SHIFT;
    q_dout_s   = '0;
    q_sat_s    = 1'b0;
`ifdef CONV_14_ACC_RELU_EN
    if (r_s[ACC_WIDTH]) begin
      q_dout_s = '0;
      q_sat_s  = 1'b0;
    end else if (r_s > MAX_POS) begin
      q_dout_s = MAX_POS[OUT_WIDTH-1:0];
      q_sat_s  = 1'b1;
    end else begin
      q_dout_s = r_s[OUT_WIDTH-1:0];
      q_sat_s  = 1'b0;
    end
`else
    if (r_s > MAX_POS) begin
      q_dout_s = MAX_POS[OUT_WIDTH-1:0];
      q_sat_s  = 1'b1;
    end else if (r_s < MIN_NEG) begin
      q_dout_s = MIN_NEG[OUT_WIDTH-1:0];
      q_sat_s  = 1'b1;
    end else begin
      q_dout_s = r_s[OUT_WIDTH-1:0];
      q_sat_s  = 1'b0;
    end
`endif
  end

  // Next-state for accumulator, term counter and the single-entry output slot.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    sat_d        = sat_q;
    dout_valid_d = dout_valid_q;
    if (final_s) begin
      acc_d        = '0;
      cnt_d        = '0;
      dout_d       = q_dout_s;
      sat_d        = q_sat_s;
      dout_valid_d = 1'b1;
    end else if (accept_s) begin
      acc_d        = sum_s;
      cnt_d        = cnt_q + CNT_ONE;
      dout_valid_d = dout_valid_q && !dout_ready;
    end else begin
      dout_valid_d = dout_valid_q && !dout_ready;
    end
  end

  // State registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      sat_q        <= sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_conv_14_acc_requant.sv
// Scoreboard bench for conv_14_acc_requant: expected results are queued on the final accept and
// compared while the DUT presents them.
module tb_conv_14_acc_requant;

  localparam int NT = 9;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [23:0]        prod_din = 24'd0;
  logic               prod_valid = 1'b0;
  logic               prod_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic               sat_flag;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] sb_q[$];
  int          macc = 0;
  int          mcnt = 0;
  logic        mv = 1'b0;
  int          n_pop = 0;
  int          obs_dout = 0;
  int          obs_sat = 0;
  logic        rand_rdy = 1'b0;

  conv_14_acc_requant dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_din   (prod_din),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_requant(input int s);
    longint r;
    logic [63:0] rb;
    r  = (longint'(s) + 64'sd128) >>> 8;
    rb = r;
`ifdef CONV_14_ACC_RELU_EN
    if (r < 0) return 17'd0;
`endif
    if (r > 64'sd32767) return {1'b1, 16'h7fff};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, rb[15:0]};
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge ap_clk) begin
    logic exp_rdy;
    logic fin;
    if (!ap_rst_n) begin
      check_val("rst_dout", dout, 0);
      check_val("rst_dout_valid", dout_valid, 0);
      check_val("rst_sat", sat_flag, 0);
      macc = 0;
      mcnt = 0;
      mv   = 1'b0;
      sb_q.delete();
    end else begin
      fin     = 1'b0;
      exp_rdy = !((mcnt == NT - 1) && mv && !dout_ready);
      check_val("prod_ready", prod_ready, exp_rdy);
      check_val("dout_valid", dout_valid, mv);
      if (mv) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 0, 1);
        end else begin
          check_val("dout", dout, $signed(sb_q[0][15:0]));
          check_val("sat_flag", sat_flag, sb_q[0][16]);
          if (dout_ready) begin
            obs_dout = dout;
            obs_sat  = sat_flag;
            void'(sb_q.pop_front());
            n_pop++;
          end
        end
      end
      if (prod_valid && exp_rdy) begin
        macc = macc + int'($signed(prod_din));
        if (mcnt == NT - 1) begin
          sb_q.push_back(ref_requant(macc));
          macc = 0;
          mcnt = 0;
          fin  = 1'b1;
        end else begin
          mcnt++;
        end
      end
      mv = fin ? 1'b1 : (mv && !dout_ready);
    end
  end

  task automatic send(input int p);
    logic [31:0] pb;
    logic ok;
    pb = p;
    ok = 1'b0;
    prod_valid = 1'b1;
    prod_din   = pb[23:0];
    for (int i = 0; i < 200; i++) begin
      if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
      @(negedge ap_clk);
      ok = prod_ready;
      @(posedge ap_clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_val("send_timeout", 0, 1);
  endtask

  task automatic drain();
    prod_valid = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge ap_clk);
      #2;
      if (sb_q.size() == 0 && !mv) break;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic batch(input int first, input int rest, input int exp_d, input int exp_s, input string tag);
    send(first);
    for (int i = 1; i < NT; i++) send(rest);
    drain();
    check_val({tag, "_dout"}, obs_dout, exp_d);
    check_val({tag, "_sat"}, obs_sat, exp_s);
  endtask

  initial begin
    int pop_base;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    batch(256, 256, 9, 0, "t256");
    batch(1000, 1000, 35, 0, "t1000");
    batch(-129, 0, -1, 0, "tm129");
    batch(-128, 0, 0, 0, "tm128");
    batch(8388607, 8388607, 32767, 1, "satpos");
`ifdef CONV_14_ACC_RELU_EN
    batch(-8388608, -8388608, 0, 0, "satneg");
`else
    batch(-8388608, -8388608, -32768, 1, "satneg");
`endif

    // Back-pressure: hold the first result while the next pixel's terms arrive.
    dout_ready = 1'b0;
    for (int i = 0; i < NT; i++) send(256);
    for (int i = 0; i < NT - 1; i++) send(1000);
    prod_valid = 1'b1;
    prod_din   = 24'd1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_val("bp_ready_low", prod_ready, 0);
      check_val("bp_hold_dout", dout, 9);
    end
    @(posedge ap_clk);
    #1 dout_ready = 1'b1;
    @(negedge ap_clk);
    check_val("bp_ready_rise", prod_ready, 1);
    @(posedge ap_clk);
    #1 prod_valid = 1'b0;
    @(negedge ap_clk);
    check_val("bp_b2b_valid", dout_valid, 1);
    check_val("bp_b2b_dout", dout, 35);
    drain();

    // Asynchronous reset while a result is held and a partial sum is pending.
    dout_ready = 1'b0;
    for (int i = 0; i < NT; i++) send(256);
    for (int i = 0; i < 4; i++) send(1000);
    prod_valid = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", dout_valid, 0);
    check_val("async_rst_dout", dout, 0);
    check_val("async_rst_sat", sat_flag, 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    dout_ready = 1'b1;
    batch(256, 256, 9, 0, "post_rst");

    // Random stream with random output back-pressure.
    pop_base = n_pop;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10 * NT; i++) begin
      if ($urandom_range(0, 1) == 0) send(int'($urandom_range(0, 4000)) - 2000);
      else send(int'($signed(24'($urandom()))));
    end
    rand_rdy = 1'b0;
    drain();
    check_val("rand_results", n_pop - pop_base, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
